// File: rtl/oam_dma.sv
// Sprite DMA: snoops $4014 writes, stalls the core and copies page $XX00-$XXFF to $2004.
// Stall is 513 CPU ticks (514 if started on an odd cycle); idle it is a transparent bus mux.
module oam_dma #(
  parameter logic [15:0] OAM_PORT = 16'h2004,
  parameter logic [15:0] TRIGGER  = 16'h4014
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  output logic        ce,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_r,
  output logic        bus_w,
  input  logic [7:0]  bus_i,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic        parity;
  logic        dma_r;
  logic        dma_w;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        trigger;

  assign trigger = ~busy & cpu_w & (cpu_a == TRIGGER);

  // reset_n is folded in so the core never advances while held in reset
  assign ce = tick & ~busy & reset_n;

  assign bus_a = busy ? dma_a : cpu_a;
  assign bus_d = busy ? dma_d : cpu_d;
  assign bus_r = busy ? dma_r : cpu_r;
  assign bus_w = busy ? dma_w : cpu_w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity <= 1'b0;
    end else if (tick) begin
      parity <= ~parity;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      page  <= 8'h00;
      idx   <= 8'h00;
      dma_r <= 1'b0;
      dma_w <= 1'b0;
      dma_a <= 16'h0000;
      dma_d <= 8'h00;
    end else begin
      dma_r <= 1'b0;
      dma_w <= 1'b0;
      if (trigger) begin
        page  <= cpu_d;
        busy  <= 1'b1;
        idx   <= 8'h00;
        state <= S_HALT;
      end else if (state == S_DONE) begin
        // releases on the clock after the last write pulse, tick or not
        busy  <= 1'b0;
        idx   <= 8'h00;
        state <= S_IDLE;
      end else if (tick) begin
        case (state)
          S_IDLE: begin
          end
          S_HALT: begin
            state <= parity ? S_ALIGN : S_READ;
          end
          S_ALIGN: begin
            state <= S_READ;
          end
          S_READ: begin
            dma_a <= {page, idx};
            dma_r <= 1'b1;
            state <= S_WRITE;
          end
          S_WRITE: begin
            dma_d <= bus_i;
            dma_a <= OAM_PORT;
            dma_w <= 1'b1;
            idx   <= idx + 8'd1;
            state <= (idx == 8'hFF) ? S_DONE : S_READ;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            idx   <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: directed sequence with random memory contents and a queue-based reference model.
`timescale 1ns/1ps
module tb_oam_dma;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_r = 1'b0;
  logic        cpu_w = 1'b0;
  logic        ce;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_r;
  logic        bus_w;
  logic [7:0]  bus_i;
  logic        busy;

  logic [7:0] mem [0:65535];
  assign bus_i = mem[bus_a];

  oam_dma dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w),
    .ce(ce), .bus_a(bus_a), .bus_d(bus_d), .bus_r(bus_r), .bus_w(bus_w),
    .bus_i(bus_i), .busy(busy)
  );

  always #20 clock = ~clock;

  int passed = 0;
  int total = 0;
  int tick_div = 1;
  int phase = 0;
  int ticks_seen = 0;

  logic [15:0] rd_q [$];
  logic [15:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          ev_q [$];
  int stall_cnt = 0;
  int clk_n = 0;
  int last_w_clk = -1;
  int fall_clk = -1;
  logic busy_d = 1'b0;

  // bus observer: records DMA-owned transactions and stalled ticks mid-clock
  always @(negedge clock) begin
    clk_n++;
    if (reset_n && busy) begin
      if (bus_r) begin
        rd_q.push_back(bus_a);
        ev_q.push_back(0);
      end
      if (bus_w) begin
        wa_q.push_back(bus_a);
        wd_q.push_back(bus_d);
        ev_q.push_back(1);
        last_w_clk = clk_n;
      end
    end
    if (reset_n && tick && !ce) stall_cnt++;
    if (busy_d && !busy) fall_clk = clk_n;
    busy_d = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    if (tick && reset_n) ticks_seen++;
    @(posedge clock);
    #1;
    phase = (phase + 1) % tick_div;
    tick = (phase == 0);
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w,
                        input string tag);
    while (!tick) cyc();
    cpu_a = a; cpu_d = d; cpu_r = r; cpu_w = w;
    #1;
    chk({tag, " bus_a"}, 32'(bus_a), 32'(a));
    chk({tag, " bus_d"}, 32'(bus_d), 32'(d));
    chk({tag, " bus_r"}, 32'(bus_r), 32'(r));
    chk({tag, " bus_w"}, 32'(bus_w), 32'(w));
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " ce"}, 32'(ce), 32'd1);
    cyc();
    cpu_r = 1'b0; cpu_w = 1'b0;
  endtask

  task automatic clear_obs();
    rd_q.delete(); wa_q.delete(); wd_q.delete(); ev_q.delete();
    stall_cnt = 0; fall_clk = -1; last_w_clk = -1;
  endtask

  // want: required parity at the HALT tick (0/1), or -1 for "start now"
  task automatic run_dma(input logic [7:0] pg, input int want, input string tag);
    bit ok;
    logic [15:0] src;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      while (!tick) cyc();
      if (want < 0 || ((ticks_seen + 1) % 2) == want) ok = 1'b1;
      else cyc();
    end
    clear_obs();
    cpu_op(TRIG, pg, 1'b0, 1'b1, {tag, " trig"});
    chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    for (int k = 0; k < 5000 && busy; k++) cyc();
    chk({tag, " busy_fall"}, 32'(busy), 32'd0);
    cyc();
    chk({tag, " reads"}, 32'(rd_q.size()), 32'd256);
    chk({tag, " writes"}, 32'(wa_q.size()), 32'd256);
    for (int i = 0; i < 256 && i < rd_q.size() && i < wa_q.size(); i++) begin
      src = {pg, 8'(i)};
      chk($sformatf("%s rd_a[%0d]", tag, i), 32'(rd_q[i]), 32'(src));
      chk($sformatf("%s wr_a[%0d]", tag, i), 32'(wa_q[i]), 32'(OAM));
      chk($sformatf("%s wr_d[%0d]", tag, i), 32'(wd_q[i]), 32'(mem[src]));
    end
    chk({tag, " events"}, 32'(ev_q.size()), 32'd512);
    for (int i = 0; i < 512 && i < ev_q.size(); i++)
      chk($sformatf("%s alt[%0d]", tag, i), 32'(ev_q[i]), 32'(i % 2));
    chk({tag, " fall_after_last_w"}, 32'(fall_clk), 32'(last_w_clk + 1));
    if (want >= 0) chk({tag, " stall"}, 32'(stall_cnt), 32'(513 + want));
  endtask

  initial begin
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'($urandom);
      mem[16'hFF00 + i] = 8'($urandom);
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // held in reset with tick high
    tick_div = 1; tick = 1'b1; reset_n = 1'b0;
    cpu_a = 16'($urandom); cpu_d = 8'($urandom);
    repeat (3) cyc();
    #1;
    chk("rst ce", 32'(ce), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bus_r", 32'(bus_r), 32'd0);
    chk("rst bus_w", 32'(bus_w), 32'd0);
    chk("rst bus_a", 32'(bus_a), 32'(cpu_a));
    reset_n = 1'b1; ticks_seen = 0; tick_div = 3; phase = 0; tick = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst ce", 32'(ce), 32'(tick));
      cyc();
      #1;
    end

    // plain pass-through accesses never start a transfer
    cpu_op(16'h4015, 8'h02, 1'b0, 1'b1, "wr4015");
    cpu_op(TRIG, 8'($urandom), 1'b1, 1'b0, "rd4014");
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom);
      if (ra == TRIG) ra = 16'h4016;
      cpu_op(ra, 8'($urandom), 1'b0, 1'b1, "wr_rand");
    end
    repeat (3) cyc();
    chk("nontrig busy", 32'(busy), 32'd0);

    run_dma(8'h02, 0, "even");
    run_dma(8'h02, 1, "odd");

    tick_div = 1; phase = 0; tick = 1'b1;
    run_dma(8'hFF, -1, "pFF");

    // reset in the middle of a transfer
    tick_div = 3; phase = 0; tick = 1'b1;
    clear_obs();
    cpu_op(TRIG, 8'h03, 1'b0, 1'b1, "mid trig");
    for (int k = 0; k < 3000 && wa_q.size() < 100; k++) cyc();
    chk("mid writes", 32'(wa_q.size()), 32'd100);
    #5;
    reset_n = 1'b0;
    ticks_seen = 0;
    #1;
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid bus_r", 32'(bus_r), 32'd0);
    chk("mid bus_w", 32'(bus_w), 32'd0);
    chk("mid ce", 32'(ce), 32'd0);
    repeat (4) cyc();
    chk("mid no_strobes", 32'(wa_q.size()), 32'd100);
    reset_n = 1'b1;
    run_dma(8'h03, 0, "p3");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
